// File: rtl/seq_cascade_comparator_if.sv
// seq_cascade_comparator_if
//   Handshake and operand bundle for seq_cascade_comparator.
//   Parameter WIDTH : operand width in bits (must match the comparator).
//   Signals:
//     start      request, sampled by the comparator only while it is not busy
//     a, b       operands, captured on an accepted start
//     e_in, g_in cascade equal-in / greater-in used when a == b
//     busy       compare in progress
//     done       one-cycle result-valid pulse
//     eq, gt     final result, held until the next done
//   Modports:
//     master : requester side (drives start/operands, observes status/result)
//     slave  : comparator side
interface seq_cascade_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e_in;
  logic             g_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b, e_in, g_in,
    input  busy, done, eq, gt
  );

  modport slave (
    input  start, a, b, e_in, g_in,
    output busy, done, eq, gt
  );
endinterface

// File: rtl/seq_cascade_comparator.sv
// seq_cascade_comparator
//   Multi-cycle magnitude comparator. Walks the captured operands DIGIT bits
//   per clock, most-significant digit first, and falls back on the cascade
//   inputs (e_in/g_in) when every digit matches.
//   Parameters:
//     WIDTH  operand width, must be a multiple of DIGIT
//     DIGIT  bits compared per clock (NDIG = WIDTH/DIGIT clocks per compare)
//     SIGNED 1 = two's complement operands (top digit compared signed)
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  seq_cascade_comparator_if.slave (start/a/b/e_in/g_in in,
//          busy/done/eq/gt out)
//   Build option:
//     SEQCMP_EARLY_EXIT_EN  when defined, the first differing digit ends the
//                           compare immediately instead of walking all digits.
module seq_cascade_comparator #(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  seq_cascade_comparator_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_width
      $error("seq_cascade_comparator: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic             e_cap;
  logic             g_cap;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic             decided;
  logic             decided_nxt;
  logic             eq_r;
  logic             gt_r;
  logic             eq_nxt;
  logic             gt_nxt;
  logic             eq_q;
  logic             gt_q;
  logic             accept;
  logic             load_out;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_diff;
  logic             dig_gt;

  // Current digit pair. Only the most-significant digit carries the sign, so
  // a signed compare is used there and unsigned everywhere below it.
  always_comb begin
    a_dig    = a_cap[int'(idx) * DIGIT +: DIGIT];
    b_dig    = b_cap[int'(idx) * DIGIT +: DIGIT];
    dig_diff = (a_dig != b_dig);
    if ((SIGNED != 0) && (idx == LAST)) begin
      dig_gt = ($signed(a_dig) > $signed(b_dig));
    end else begin
      dig_gt = (a_dig > b_dig);
    end
  end

  // Next-state logic. The first differing digit decides the result and sets
  // 'decided' so later digits cannot overwrite it; if nothing differs the
  // cascade inputs captured with the operands become the result. load_out
  // marks the edge that enters DONE, which is the only time the visible
  // eq/gt registers change.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    decided_nxt = decided;
    eq_nxt      = eq_r;
    gt_nxt      = gt_r;
    accept      = 1'b0;
    load_out    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          accept      = 1'b1;
          state_nxt   = RUN;
          idx_nxt     = LAST;
          decided_nxt = 1'b0;
        end
      end
      RUN: begin
        if (!decided && dig_diff) begin
          decided_nxt = 1'b1;
          eq_nxt      = 1'b0;
          gt_nxt      = dig_gt;
        end else if (!decided && (idx == '0)) begin
          eq_nxt = e_cap;
          gt_nxt = g_cap;
        end
        if (idx == '0) begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end else begin
          idx_nxt = idx - 1'b1;
        end
`ifdef SEQCMP_EARLY_EXIT_EN
        if (!decided && dig_diff) begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, working registers and operand capture. Operands and cascade bits
  // are only written on an accepted start so the bus may change freely while
  // a compare runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      decided <= 1'b0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      a_cap   <= '0;
      b_cap   <= '0;
      e_cap   <= 1'b0;
      g_cap   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      decided <= decided_nxt;
      eq_r    <= eq_nxt;
      gt_r    <= gt_nxt;
      if (load_out) begin
        eq_q <= eq_nxt;
        gt_q <= gt_nxt;
      end
      if (accept) begin
        a_cap <= bus.a;
        b_cap <= bus.b;
        e_cap <= bus.e_in;
        g_cap <= bus.g_in;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;

endmodule

// File: tb/tb_seq_cascade_comparator.sv
// tb_seq_cascade_comparator
//   Self-checking bench for seq_cascade_comparator. Two instances share one
//   stimulus stream: one unsigned, one signed, both WIDTH=8 / DIGIT=2.
//   Expected results come from whole-operand arithmetic; expected latency from
//   the position of the highest differing bit (SEQCMP_EARLY_EXIT_EN aware).
module tb_seq_cascade_comparator;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int ND = W / D;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] prev_u = 2'b00;
  logic [1:0] prev_s = 2'b00;

  seq_cascade_comparator_if #(.WIDTH(W)) bus_u ();
  seq_cascade_comparator_if #(.WIDTH(W)) bus_s ();

  seq_cascade_comparator #(.WIDTH(W), .DIGIT(D), .SIGNED(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  seq_cascade_comparator #(.WIDTH(W), .DIGIT(D), .SIGNED(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  // Reference result {eq, gt} from whole-operand comparison.
  function automatic logic [1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic e, input logic g, input bit sgn);
    if (a == b) return {e, g};
    if (sgn) return {1'b0, ($signed(a) > $signed(b))};
    return {1'b0, (a > b)};
  endfunction

  // Reference latency in clocks from the accepting edge to the done cycle.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
`ifdef SEQCMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) return ND - (i / D);
    end
`endif
    if (x == '0) return ND;
    return ND;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic e, input logic g, input logic s);
    bus_u.start = s; bus_u.a = a; bus_u.b = b; bus_u.e_in = e; bus_u.g_in = g;
    bus_s.start = s; bus_s.a = a; bus_s.b = b; bus_s.e_in = e; bus_s.g_in = g;
  endtask

  task automatic drive_junk(input logic s);
    logic [W-1:0] ja;
    logic [W-1:0] jb;
    ja = W'($urandom);
    jb = W'($urandom);
    drive(ja, jb, 1'($urandom), 1'($urandom), s);
  endtask

  // Issues one compare and observes both instances until done (bounded).
  task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic e, input logic g,
                            output int lat_u, output int lat_s, output int busy_cnt,
                            output bit stable, output logic [1:0] res_u,
                            output logic [1:0] res_s);
    lat_u = -1; lat_s = -1; busy_cnt = 0; stable = 1'b1;
    res_u = 2'bxx; res_s = 2'bxx;
    @(negedge clk);
    drive(a, b, e, g, 1'b1);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      drive_junk(1'b0);
      if (bus_u.busy) busy_cnt++;
      if (bus_u.busy && ({bus_u.eq, bus_u.gt} !== prev_u)) stable = 1'b0;
      if (bus_s.busy && ({bus_s.eq, bus_s.gt} !== prev_s)) stable = 1'b0;
      if (lat_u < 0 && bus_u.done) begin lat_u = n; res_u = {bus_u.eq, bus_u.gt}; end
      if (lat_s < 0 && bus_s.done) begin lat_s = n; res_s = {bus_s.eq, bus_s.gt}; end
      if (lat_u >= 0 && lat_s >= 0) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if ({bus_u.busy, bus_u.done, bus_u.eq, bus_u.gt} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_u busy/done/eq/gt got %b want 0000",
               {bus_u.busy, bus_u.done, bus_u.eq, bus_u.gt});
    end
    compared++;
    if ({bus_s.busy, bus_s.done, bus_s.eq, bus_s.gt} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_s busy/done/eq/gt got %b want 0000",
               {bus_s.busy, bus_s.done, bus_s.eq, bus_s.gt});
    end
    rst = 1'b0;
    prev_u = 2'b00;
    prev_s = 2'b00;
  endtask

  task automatic test_cascade;
    logic [W-1:0] av [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h00};
    logic         ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic         gv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lu, ls, bc;
    bit st;
    logic [1:0] ru, rs, exp;
    for (int i = 0; i < 4; i++) begin
      exp = {ev[i], gv[i]};
      do_compare(av[i], av[i], ev[i], gv[i], lu, ls, bc, st, ru, rs);
      compared++;
      if (lu !== ND) begin
        mismatched++;
        $display("[TB] FAIL cascade_lat[%0d] got %0d want %0d", i, lu, ND);
      end
      compared++;
      if (bc !== ND) begin
        mismatched++;
        $display("[TB] FAIL cascade_busy[%0d] got %0d want %0d", i, bc, ND);
      end
      compared++;
      if (ru !== exp || rs !== exp) begin
        mismatched++;
        $display("[TB] FAIL cascade_res[%0d] got u=%b s=%b want %b", i, ru, rs, exp);
      end
      compared++;
      if (!st) begin
        mismatched++;
        $display("[TB] FAIL cascade_hold[%0d] got changed want held", i);
      end
      prev_u = exp;
      prev_s = exp;
    end
  endtask

  task automatic test_signed;
    int lu, ls, bc;
    bit st;
    logic [1:0] ru, rs;
    do_compare(8'h80, 8'h7F, 1'b0, 1'b0, lu, ls, bc, st, ru, rs);
    compared++;
    if (ru !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL signed_80_7f_u got %b want 01", ru);
    end
    compared++;
    if (rs !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL signed_80_7f_s got %b want 00", rs);
    end
    prev_u = ru === 2'b01 ? 2'b01 : 2'b01;
    prev_s = 2'b00;
    do_compare(8'h7F, 8'h80, 1'b1, 1'b1, lu, ls, bc, st, ru, rs);
    compared++;
    if (ru !== 2'b00 || rs !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL signed_7f_80 got u=%b s=%b want u=00 s=01", ru, rs);
    end
    compared++;
    if (!st) begin
      mismatched++;
      $display("[TB] FAIL signed_hold got changed want held");
    end
    prev_u = 2'b00;
    prev_s = 2'b01;
  endtask

  task automatic test_early_exit;
    int lu, ls, bc, want;
    bit st;
    logic [1:0] ru, rs;
`ifdef SEQCMP_EARLY_EXIT_EN
    want = 1;
`else
    want = ND;
`endif
    do_compare(8'hC0, 8'h40, 1'b0, 1'b0, lu, ls, bc, st, ru, rs);
    compared++;
    if (lu !== want || ls !== want) begin
      mismatched++;
      $display("[TB] FAIL early_lat_c0_40 got u=%0d s=%0d want %0d", lu, ls, want);
    end
    compared++;
    if (ru !== 2'b01 || rs !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL early_res_c0_40 got u=%b s=%b want u=01 s=00", ru, rs);
    end
    prev_u = 2'b01;
    prev_s = 2'b00;
    do_compare(8'hA4, 8'hA5, 1'b1, 1'b0, lu, ls, bc, st, ru, rs);
    compared++;
    if (lu !== ND || bc !== ND) begin
      mismatched++;
      $display("[TB] FAIL early_lat_lsd got lat=%0d busy=%0d want %0d", lu, bc, ND);
    end
    compared++;
    if (ru !== 2'b00 || rs !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL early_res_lsd got u=%b s=%b want 00", ru, rs);
    end
    prev_u = 2'b00;
    prev_s = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1 = 8'h5A, b1 = 8'h59, a2 = 8'h13, b2 = 8'hF3;
    int lat1, gap;
    logic [1:0] r1u, r1s, r2u, r2s;
    lat1 = -1; gap = -1;
    r1u = 2'bxx; r1s = 2'bxx; r2u = 2'bxx; r2s = 2'bxx;
    @(negedge clk);
    drive(a1, b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (bus_u.done) begin
        lat1 = n;
        r1u = {bus_u.eq, bus_u.gt};
        r1s = {bus_s.eq, bus_s.gt};
        drive(a2, b2, 1'b1, 1'b0, 1'b1);
        break;
      end
      drive_junk(1'b1);
    end
    compared++;
    if (lat1 !== model_lat(a1, b1)) begin
      mismatched++;
      $display("[TB] FAIL b2b_first_lat got %0d want %0d", lat1, model_lat(a1, b1));
    end
    compared++;
    if (r1u !== model_res(a1, b1, 1'b0, 1'b0, 0) || r1s !== model_res(a1, b1, 1'b0, 1'b0, 1)) begin
      mismatched++;
      $display("[TB] FAIL b2b_first_res got u=%b s=%b want u=%b s=%b", r1u, r1s,
               model_res(a1, b1, 1'b0, 1'b0, 0), model_res(a1, b1, 1'b0, 1'b0, 1));
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus_u.done) begin
        gap = n;
        r2u = {bus_u.eq, bus_u.gt};
        r2s = {bus_s.eq, bus_s.gt};
        break;
      end
      drive_junk(1'b0);
    end
    compared++;
    if (gap !== model_lat(a2, b2) + 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_gap got %0d want %0d", gap, model_lat(a2, b2) + 1);
    end
    compared++;
    if (r2u !== model_res(a2, b2, 1'b1, 1'b0, 0) || r2s !== model_res(a2, b2, 1'b1, 1'b0, 1)) begin
      mismatched++;
      $display("[TB] FAIL b2b_second_res got u=%b s=%b want u=%b s=%b", r2u, r2s,
               model_res(a2, b2, 1'b1, 1'b0, 0), model_res(a2, b2, 1'b1, 1'b0, 1));
    end
    prev_u = model_res(a2, b2, 1'b1, 1'b0, 0);
    prev_s = model_res(a2, b2, 1'b1, 1'b0, 1);
  endtask

  task automatic test_reset_mid_run;
    int lu, ls, bc;
    bit st, saw_done;
    logic [1:0] ru, rs;
    do_compare(8'h33, 8'h33, 1'b1, 1'b1, lu, ls, bc, st, ru, rs);
    prev_u = 2'b11;
    prev_s = 2'b11;
    @(negedge clk);
    drive(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_junk(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus_u.busy, bus_u.done, bus_u.eq, bus_u.gt} !== 4'b0000 ||
        {bus_s.busy, bus_s.done, bus_s.eq, bus_s.gt} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL async_reset got u=%b s=%b want 0000",
               {bus_u.busy, bus_u.done, bus_u.eq, bus_u.gt},
               {bus_s.busy, bus_s.done, bus_s.eq, bus_s.gt});
    end
    @(negedge clk);
    rst = 1'b0;
    prev_u = 2'b00;
    prev_s = 2'b00;
    saw_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus_u.done || bus_s.done || bus_u.busy) saw_done = 1'b1;
    end
    compared++;
    if (saw_done) begin
      mismatched++;
      $display("[TB] FAIL reset_no_done got activity want idle");
    end
    do_compare(8'hE1, 8'h1E, 1'b0, 1'b0, lu, ls, bc, st, ru, rs);
    compared++;
    if (ru !== 2'b01 || rs !== 2'b00 || lu !== model_lat(8'hE1, 8'h1E)) begin
      mismatched++;
      $display("[TB] FAIL after_reset got u=%b s=%b lat=%0d want u=01 s=00 lat=%0d",
               ru, rs, lu, model_lat(8'hE1, 8'h1E));
    end
    prev_u = 2'b01;
    prev_s = 2'b00;
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic e, g;
    int lu, ls, bc, el, mode;
    bit st;
    logic [1:0] ru, rs, eu, es;
    for (int i = 0; i < 30; i++) begin
      a    = W'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      b = W'($urandom);
      else if (mode == 1) b = a;
      else                b = a ^ (W'(1) << $urandom_range(0, W - 1));
      e  = 1'($urandom);
      g  = 1'($urandom);
      eu = model_res(a, b, e, g, 0);
      es = model_res(a, b, e, g, 1);
      el = model_lat(a, b);
      do_compare(a, b, e, g, lu, ls, bc, st, ru, rs);
      compared++;
      if (ru !== eu || rs !== es) begin
        mismatched++;
        $display("[TB] FAIL rand_res[%0d] a=%h b=%h e=%b g=%b got u=%b s=%b want u=%b s=%b",
                 i, a, b, e, g, ru, rs, eu, es);
      end
      compared++;
      if (lu !== el || ls !== el || bc !== el) begin
        mismatched++;
        $display("[TB] FAIL rand_lat[%0d] a=%h b=%h got u=%0d s=%0d busy=%0d want %0d",
                 i, a, b, lu, ls, bc, el);
      end
      compared++;
      if (!st) begin
        mismatched++;
        $display("[TB] FAIL rand_hold[%0d] got changed want held", i);
      end
      prev_u = eu;
      prev_s = es;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cascade();
    test_signed();
    test_early_exit();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_cascade_comparator.md
Name: seq_cascade_comparator

Overview:
Multi-cycle magnitude comparator for WIDTH-bit operands. It walks the operands DIGIT bits per clock, most-significant digit first. It keeps the two-bit cascade convention of the team's combinational compare cells: eq/gt inputs from a lower-significance stage decide the result when all digits are equal. It sits beside datapath blocks that cannot afford a wide single-cycle comparator, and it exposes a start/busy/done handshake.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT (elaboration error otherwise).
DIGIT, 2, bits compared per clock; NDIG = WIDTH/DIGIT digits.
SIGNED, 0, 1 = operands are two's complement; the most-significant digit is compared signed, all other digits unsigned.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
a  in  WIDTH  operand A; captured on an accepted start
b  in  WIDTH  operand B; captured on an accepted start
e_in  in  1  cascade equal-in; result eq when a==b
g_in  in  1  cascade greater-in; result gt when a==b
busy  out  1  high while a compare is in progress
done  out  1  one-cycle pulse; result valid
eq  out  1  final equal result
gt  out  1  final greater result

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, eq=0, gt=0, digit index=0, captured operands and cascade bits=0.
- States:
  - IDLE: busy=0. On start, capture a, b, e_in, g_in; set index=NDIG-1; go to RUN. Later changes to a/b/e_in/g_in have no effect on the running compare.
  - RUN: busy=1. Each edge compares digit[index] of A vs B.
    - Digits differ: eq_r<=0, gt_r<=(A_d>B_d). Use a signed compare when SIGNED=1 and index==NDIG-1.
    - Digits equal: no decision; index decrements.
    - After digit 0 with no difference: eq_r<=e_in_cap, gt_r<=g_in_cap.
    - A decided flag freezes eq_r/gt_r once any digit differs. Later digits are still walked unless early exit is enabled.
    - After processing digit 0, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; eq/gt are driven from eq_r/gt_r; then go to IDLE.
- start handling:
  - start during the DONE cycle is accepted (back-to-back; next compare begins in RUN on the following edge).
  - start during RUN is ignored.
- Latency: start sampled at edge k → done high in the cycle after edge k+NDIG. One compare every NDIG+1 cycles.
- eq/gt hold their last value until the next DONE. They never change in the middle of a compare.
- Result properties: eq and gt are never both 1 unless the e_in/g_in inputs were both 1 when captured; in that case both are passed through unmodified.
- Reset during RUN or DONE: immediate return to reset values; no done pulse for the aborted compare.

Optional Feature:
SEQCMP_EARLY_EXIT_EN:
- Defined: in RUN, the first differing digit sends the FSM straight to DONE. done goes high in the cycle after the edge that processed that digit. Latency becomes m cycles, where m = 1-based position of the first differing digit from the MSB.
- Undefined: fixed NDIG-cycle latency for every compare.

Test Plan:
- WIDTH=8, DIGIT=2, SIGNED=0: a=0xA5, b=0xA5, e_in=1, g_in=0, start one cycle → done 4 cycles after the start edge; eq=1, gt=0; busy high for exactly 4 cycles.
- Same operands, e_in=0, g_in=1 → eq=0, gt=1 (cascade pass-through).
- a=0x80, b=0x7F: SIGNED=0 → gt=1, eq=0; SIGNED=1 → gt=0, eq=0.
- a=0xC0, b=0x40, macro defined → done 1 cycle after the start edge, gt=1. Macro undefined → done after 4 cycles with the same result.
- Start held high through RUN and operands changed mid-compare → ignored; result reflects the captured values. Second start during the DONE cycle → accepted; next done exactly 5 cycles after the first done.
- rst asserted mid-RUN (cycle 2) → busy/done/eq/gt drop to 0 asynchronously; no done pulse until a new start.
